// File: rtl/div_unit.sv
`timescale 1ns/1ps
// div_unit: 32-step restoring signed divider with MIPS DIV semantics.
// hi = remainder, lo = quotient; results are sign-corrected in the DONE state.
// Optional macro DIV_ZERO_EXC_EN adds the div0 port and skips the iteration
// when the divisor is zero.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
`ifdef DIV_ZERO_EXC_EN
  output logic             div0,
`endif
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [5:0] LastCnt = 6'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               sa_q, sb_q;
  logic [WIDTH-1:0]   dvd_q;    // |a|, shifted out MSB first
  logic [WIDTH-1:0]   abs_b_q;
  logic [2*WIDTH-1:0] work_q;   // {remainder, quotient}
  logic [5:0]         cnt_q;
`ifdef DIV_ZERO_EXC_EN
  logic               dz_q;
`endif

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix;
  logic             start_dz;

  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

`ifdef DIV_ZERO_EXC_EN
  assign start_dz = (b == '0);
`else
  assign start_dz = 1'b0;
`endif

  // One restoring step: shift in next dividend bit, trial-subtract |b| at WIDTH+1 bits.
  always_comb begin
    rem_sh  = {work_q[2*WIDTH-1:WIDTH], dvd_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, abs_b_q};
    qbit    = ~diff[WIDTH];
    rem_nx  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx  = {work_q[WIDTH-2:0], qbit};
    quo_fix = (sa_q ^ sb_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix = sa_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  end

  assign busy = (state_q == StRun);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = start_dz ? StDone : StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, iteration and result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dvd_q   <= '0;
      abs_b_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      dz_q    <= 1'b0;
      div0    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q    <= a[WIDTH-1];
            sb_q    <= b[WIDTH-1];
            dvd_q   <= abs_a;
            abs_b_q <= abs_b;
            work_q  <= '0;
            cnt_q   <= '0;
`ifdef DIV_ZERO_EXC_EN
            dz_q    <= start_dz;
            div0    <= 1'b0;
`endif
          end
        end
        StRun: begin
          work_q <= {rem_nx, quo_nx};
          dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
          cnt_q  <= cnt_q + 6'd1;
        end
        StDone: begin
          done <= 1'b1;
`ifdef DIV_ZERO_EXC_EN
          if (dz_q) begin
            div0 <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
`else
          hi <= rem_fix;
          lo <= quo_fix;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
